// File: rtl/ldgm_row_xor_acc_if.sv
// Bundle of the vector-in, ROM and result-out signals of the LDGM row XOR
// accumulator. The slave modport is the accumulator's view; the master
// modport is the environment (vector source, ROM and result sink).
interface ldgm_row_xor_acc_if #(
    parameter int ADDR_W = 9,
    parameter int DAT_W  = 2100,
    parameter int ROWS   = 512
);
    logic [ROWS-1:0]   x_in;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DAT_W-1:0]  rom_dout;
    logic [DAT_W-1:0]  y_out;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  x_in, in_valid, rom_dout, out_ready,
        output in_ready, rom_addr, y_out, out_valid
    );

    modport master (
        output x_in, in_valid, rom_dout, out_ready,
        input  in_ready, rom_addr, y_out, out_valid
    );
endinterface

// File: rtl/ldgm_row_xor_acc.sv
// GF(2) vector-matrix multiply y = x * A for LDGM signature generation.
// Walks every row of the matrix ROM once per operation and XOR-accumulates
// the rows whose x bit is set. Latency does not depend on the data.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for a vector
// RUN   | issuing ROM addresses 0..ROWS-1, one row per cycle
// DRAIN | no new addresses; waiting ROM_LAT cycles for the tail rows
// DONE  | result held on y_out with out_valid high until accepted
module ldgm_row_xor_acc #(
    parameter int ADDR_W  = 9,
    parameter int DAT_W   = 2100,
    parameter int ROWS    = 512,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    ldgm_row_xor_acc_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DCW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [ROWS-1:0]   x_reg;
    logic [ADDR_W-1:0] cnt;
    logic [DCW-1:0]    drain_cnt;
    logic [ROM_LAT-1:0] pipe_valid;
    logic [ROM_LAT-1:0] pipe_sel;
    logic [DAT_W-1:0]  acc;

    logic accept;
    logic last_row;
    logic drain_done;
    logic absorb;

    assign accept     = bus.in_valid && (state == IDLE);
    assign last_row   = (cnt == ADDR_W'(ROWS - 1));
    assign drain_done = (drain_cnt == '0);
    // The select bit travels alongside the ROM read so it lines up with rom_dout.
    assign absorb     = pipe_valid[ROM_LAT-1] && pipe_sel[ROM_LAT-1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last_row)      state_nxt = DRAIN;
            DRAIN:   if (drain_done)    state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Row counter, vector shifter, select pipeline, drain timer and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg      <= '0;
            cnt        <= '0;
            drain_cnt  <= '0;
            pipe_valid <= '0;
            pipe_sel   <= '0;
            acc        <= '0;
        end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_sel[i]   <= pipe_sel[i-1];
            end
            // x_reg shifts right each RUN cycle, so bit 0 is always x[cnt].
            pipe_valid[0] <= (state == RUN);
            pipe_sel[0]   <= (state == RUN) && x_reg[0];

            if (accept) begin
                x_reg <= bus.x_in;
                cnt   <= '0;
                acc   <= '0;
            end else begin
                if (state == RUN) begin
                    x_reg <= x_reg >> 1;
                    if (last_row) begin
                        drain_cnt <= DCW'(ROM_LAT - 1);
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                if ((state == DRAIN) && !drain_done) begin
                    drain_cnt <= drain_cnt - DCW'(1);
                end
                if (absorb) begin
                    acc <= acc ^ bus.rom_dout;
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.rom_addr  = cnt;
    assign bus.y_out     = acc;

endmodule
